// File: rtl/poly_line_sequencer.sv
// Polygon edge scheduler: stores up to MAXV vertices and runs the shared line engine once per edge.
// Define POLY_LINE_SEQUENCER_CLOSE_EN to compile in the closing edge (last vertex back to vertex 0).
module poly_line_sequencer #(
  parameter int CORDW = 12,
  parameter int MAXV  = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      vtx_we,
  input  logic [$clog2(MAXV)-1:0]   vtx_idx,
  input  logic signed [CORDW-1:0]   vtx_x,
  input  logic signed [CORDW-1:0]   vtx_y,
  input  logic [$clog2(MAXV):0]     nverts,
  input  logic                      closed,
  input  logic                      go,
  output logic                      busy,
  output logic                      done,
  output logic                      line_start,
  output logic signed [CORDW-1:0]   line_x0,
  output logic signed [CORDW-1:0]   line_y0,
  output logic signed [CORDW-1:0]   line_x1,
  output logic signed [CORDW-1:0]   line_y1,
  output logic [$clog2(MAXV)-1:0]   line_idx,
  input  logic                      line_done
);

  localparam int IW = $clog2(MAXV);
  localparam int CW = IW + 1;

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_START, S_WAIT, S_FIN} state_t;

  state_t                  state, state_nx;
  logic signed [CORDW-1:0] vx [MAXV];
  logic signed [CORDW-1:0] vy [MAXV];
  logic [CW-1:0]           cnt;
  logic [CW-1:0]           e_r;
  logic [CW-1:0]           n_clamp;
  logic [CW-1:0]           e_go;
  logic [IW-1:0]           nxt_idx;
  logic                    last;
  logic                    closed_eff;

`ifdef POLY_LINE_SEQUENCER_CLOSE_EN
  logic [CW-1:0] n_r;

  assign closed_eff = closed;
  // Edge from vertex n-1 wraps back to slot 0.
  assign nxt_idx = ((cnt + CW'(1)) == n_r) ? '0 : (cnt[IW-1:0] + IW'(1));
`else
  logic closed_unused;

  assign closed_eff    = 1'b0;
  assign closed_unused = closed;
  assign nxt_idx       = cnt[IW-1:0] + IW'(1);
`endif

  assign n_clamp = (nverts > CW'(MAXV)) ? CW'(MAXV) : nverts;

  // Two vertices closed would only retrace the same segment, so it stays one edge.
  always_comb begin
    e_go = '0;
    if (n_clamp >= CW'(2)) begin
      if (closed_eff && (n_clamp != CW'(2)))
        e_go = n_clamp;
      else
        e_go = n_clamp - CW'(1);
    end
  end

  assign last = (cnt == (e_r - CW'(1)));

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < MAXV; i++) begin
        vx[i] <= '0;
        vy[i] <= '0;
      end
    end else if (vtx_we && (state == S_IDLE)) begin
      vx[vtx_idx] <= vtx_x;
      vy[vtx_idx] <= vtx_y;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt      <= '0;
      e_r      <= '0;
      line_x0  <= '0;
      line_y0  <= '0;
      line_x1  <= '0;
      line_y1  <= '0;
      line_idx <= '0;
`ifdef POLY_LINE_SEQUENCER_CLOSE_EN
      n_r      <= '0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (go) begin
            cnt <= '0;
            e_r <= e_go;
`ifdef POLY_LINE_SEQUENCER_CLOSE_EN
            n_r <= n_clamp;
`endif
          end
        end
        S_LOAD: begin
          line_x0  <= vx[cnt[IW-1:0]];
          line_y0  <= vy[cnt[IW-1:0]];
          line_x1  <= vx[nxt_idx];
          line_y1  <= vy[nxt_idx];
          line_idx <= cnt[IW-1:0];
        end
        S_WAIT: begin
          if (line_done && !last)
            cnt <= cnt + CW'(1);
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst)
      state <= S_IDLE;
    else
      state <= state_nx;
  end

  always_comb begin
    state_nx   = state;
    busy       = 1'b0;
    done       = 1'b0;
    line_start = 1'b0;
    case (state)
      S_IDLE: begin
        if (go)
          state_nx = (e_go == '0) ? S_FIN : S_LOAD;
      end
      S_LOAD: begin
        busy     = 1'b1;
        state_nx = S_START;
      end
      S_START: begin
        busy       = 1'b1;
        line_start = 1'b1;
        state_nx   = S_WAIT;
      end
      S_WAIT: begin
        busy = 1'b1;
        if (line_done)
          state_nx = last ? S_FIN : S_LOAD;
      end
      S_FIN: begin
        done     = 1'b1;
        state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_poly_line_sequencer.sv
// Directed bench for poly_line_sequencer with a fixed-latency line engine model.
// Expected closed-pass edge count follows POLY_LINE_SEQUENCER_CLOSE_EN.
module tb_poly_line_sequencer;

  localparam int CORDW = 12;
  localparam int MAXV  = 8;
  localparam int IW    = $clog2(MAXV);
  localparam int NW    = IW + 1;
`ifdef POLY_LINE_SEQUENCER_CLOSE_EN
  localparam int E_CLOSED4 = 4;
`else
  localparam int E_CLOSED4 = 3;
`endif

  logic                    clk = 1'b0;
  logic                    rst;
  logic                    vtx_we;
  logic [IW-1:0]           vtx_idx;
  logic signed [CORDW-1:0] vtx_x, vtx_y;
  logic [NW-1:0]           nverts;
  logic                    closed;
  logic                    go;
  logic                    busy, done, line_start;
  logic signed [CORDW-1:0] line_x0, line_y0, line_x1, line_y1;
  logic [IW-1:0]           line_idx;
  logic                    line_done = 1'b0;
  logic                    force_ld;

  poly_line_sequencer #(.CORDW(CORDW), .MAXV(MAXV)) dut (
    .clk(clk), .rst(rst), .vtx_we(vtx_we), .vtx_idx(vtx_idx),
    .vtx_x(vtx_x), .vtx_y(vtx_y), .nverts(nverts), .closed(closed), .go(go),
    .busy(busy), .done(done), .line_start(line_start),
    .line_x0(line_x0), .line_y0(line_y0), .line_x1(line_x1), .line_y1(line_y1),
    .line_idx(line_idx), .line_done(line_done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Engine model and monitor, sampled on the falling edge.
  int sx0[64], sy0[64], sx1[64], sy1[64], sidx[64], scyc[64], ld_cyc[64];
  int nstart = 0, nld = 0, ndone = 0, eng_cnt = 0, done_cyc = 0, done_busy = 0;

  always @(negedge clk) begin
    line_done = 1'b0;
    if (eng_cnt > 0) begin
      eng_cnt--;
      if (eng_cnt == 0) begin
        line_done = 1'b1;
        ld_cyc[nld] = cyc;
        nld++;
      end
    end
    if (force_ld) line_done = 1'b1;
    if (line_start) begin
      sx0[nstart]  = int'(line_x0);
      sy0[nstart]  = int'(line_y0);
      sx1[nstart]  = int'(line_x1);
      sy1[nstart]  = int'(line_y1);
      sidx[nstart] = int'(line_idx);
      scyc[nstart] = cyc;
      nstart++;
      eng_cnt = 5;
    end
    if (done) begin
      done_cyc  = cyc;
      done_busy = int'(busy);
      ndone++;
    end
  end

  int n_assert = 0;
  int n_fail   = 0;
  int vxs[4] = '{20, 100, 100, 20};
  int vys[4] = '{20, 100, 350, 430};

  task automatic check_val(input string tag, input int obs, input int exp);
    n_assert++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic write_vtx(input int i, input int x, input int y);
    vtx_we  = 1'b1;
    vtx_idx = IW'(i);
    vtx_x   = CORDW'(x);
    vtx_y   = CORDW'(y);
    step();
    vtx_we  = 1'b0;
  endtask

  task automatic go_pass(input int n, input bit cl, output int c);
    go     = 1'b1;
    nverts = NW'(n);
    closed = cl;
    c      = cyc;
    step();
    go     = 1'b0;
  endtask

  task automatic wait_done(input int target, input string tag);
    int t = 0;
    while (ndone < target && t < 300) begin
      step();
      t++;
    end
    check_val(tag, int'(ndone >= target), 1);
  endtask

  task automatic wait_starts(input int target, input string tag);
    int t = 0;
    while (nstart < target && t < 300) begin
      step();
      t++;
    end
    check_val(tag, int'(nstart >= target), 1);
  endtask

  // Edge i of the four-vertex shape runs vertex i -> vertex (i+1) mod 4.
  task automatic check_edges(input int base, input int ne, input string tag);
    for (int i = 0; i < ne; i++) begin
      int j;
      j = (i + 1) % 4;
      check_val($sformatf("%s_x0_%0d", tag, i), sx0[base+i], vxs[i]);
      check_val($sformatf("%s_y0_%0d", tag, i), sy0[base+i], vys[i]);
      check_val($sformatf("%s_x1_%0d", tag, i), sx1[base+i], vxs[j]);
      check_val($sformatf("%s_y1_%0d", tag, i), sy1[base+i], vys[j]);
      check_val($sformatf("%s_idx_%0d", tag, i), sidx[base+i], i);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: observed no finish expected finish");
    $fatal(1);
  end

  initial begin
    int c, st0, nd0, ld0, sum;
    rst = 1'b1; go = 1'b0; vtx_we = 1'b0; vtx_idx = '0; vtx_x = '0; vtx_y = '0;
    nverts = '0; closed = 1'b0; force_ld = 1'b0;
    repeat (3) step();
    rst = 1'b0;
    step();
    check_val("rst_busy", int'(busy), 0);
    check_val("rst_done", int'(done), 0);
    check_val("rst_start", int'(line_start), 0);
    check_val("rst_x0", int'(line_x0), 0);
    check_val("rst_y1", int'(line_y1), 0);
    check_val("rst_idx", int'(line_idx), 0);

    for (int i = 0; i < 4; i++) write_vtx(i, vxs[i], vys[i]);

    // Pass 1: closed quad, with a go and a vertex write injected during WAIT.
    st0 = nstart; nd0 = ndone; ld0 = nld;
    go_pass(4, 1'b1, c);
    check_val("p1_busy_c1", int'(busy), 1);
    check_val("p1_nostart_c1", int'(line_start), 0);
    step();
    check_val("p1_start_c2", int'(line_start), 1);
    check_val("p1_x0_c2", int'(line_x0), 20);
    check_val("p1_y1_c2", int'(line_y1), 100);
    step(); step();
    go = 1'b1; nverts = NW'(1); vtx_we = 1'b1; vtx_idx = '0; vtx_x = 7; vtx_y = 7;
    step();
    go = 1'b0; vtx_we = 1'b0;
    check_val("p1_busy_mid", int'(busy), 1);
    check_val("p1_x0_hold", int'(line_x0), 20);
    check_val("p1_x1_hold", int'(line_x1), 100);
    wait_done(nd0 + 1, "p1_done_seen");
    check_val("p1_nstarts", nstart - st0, E_CLOSED4);
    check_edges(st0, E_CLOSED4, "p1");
    check_val("p1_start_cyc", scyc[st0], c + 2);
    check_val("p1_gap", scyc[st0+1] - ld_cyc[ld0], 2);
    check_val("p1_done_lat", done_cyc - ld_cyc[nld-1], 1);
    check_val("p1_done_busy", done_busy, 0);

    // Pass 2: open polyline, go issued in the first IDLE cycle after done.
    st0 = nstart;
    go_pass(4, 1'b0, c);
    check_val("p2_go_accepted", int'(busy), 1);
    step();
    force_ld = 1'b1;
    step();
    force_ld = 1'b0;
    wait_done(nd0 + 2, "p2_done_seen");
    check_val("p2_nstarts", nstart - st0, 3);
    check_edges(st0, 3, "p2");
    check_val("p2_last_x1", sx1[nstart-1], 20);
    check_val("p2_last_y1", sy1[nstart-1], 430);
    check_val("p12_ndone", ndone - nd0, 2);

    // Degenerate pass: one vertex.
    step();
    st0 = nstart; nd0 = ndone;
    go_pass(1, 1'b1, c);
    check_val("n1_done_c1", int'(done), 1);
    check_val("n1_busy_c1", int'(busy), 0);
    repeat (5) step();
    check_val("n1_nstarts", nstart - st0, 0);
    check_val("n1_ndone", ndone - nd0, 1);

    // Two vertices closed: a single edge.
    st0 = nstart; nd0 = ndone;
    go_pass(2, 1'b1, c);
    wait_done(nd0 + 1, "n2_done_seen");
    check_val("n2_nstarts", nstart - st0, 1);
    check_edges(st0, 1, "n2");

    // nverts above MAXV clamps to 8; slots 4..7 still hold reset zeros.
    step();
    st0 = nstart; nd0 = ndone;
    go_pass(12, 1'b0, c);
    wait_done(nd0 + 1, "clamp_done_seen");
    check_val("clamp_nstarts", nstart - st0, 7);
    check_val("clamp_last_idx", sidx[nstart-1], 6);
    check_val("clamp_e3_y0", sy0[st0+3], 430);
    check_val("clamp_e3_x1", sx1[st0+3], 0);

    // Reset during the second edge's WAIT.
    step();
    st0 = nstart; nd0 = ndone;
    go_pass(4, 1'b0, c);
    wait_starts(st0 + 2, "rst_mid_2nd_start");
    step(); step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_val("rmid_busy", int'(busy), 0);
    check_val("rmid_start", int'(line_start), 0);
    check_val("rmid_done", int'(done), 0);
    check_val("rmid_x0", int'(line_x0), 0);
    check_val("rmid_y0", int'(line_y0), 0);
    check_val("rmid_x1", int'(line_x1), 0);
    check_val("rmid_y1", int'(line_y1), 0);
    check_val("rmid_idx", int'(line_idx), 0);
    repeat (20) step();
    check_val("rmid_no_more_starts", nstart - st0, 2);
    check_val("rmid_no_done", ndone - nd0, 0);

    st0 = nstart;
    go_pass(4, 1'b1, c);
    wait_done(nd0 + 1, "post_rst_done_seen");
    check_val("post_rst_nstarts", nstart - st0, E_CLOSED4);
    sum = 0;
    for (int i = st0; i < nstart; i++)
      sum += (sx0[i] != 0) + (sy0[i] != 0) + (sx1[i] != 0) + (sy1[i] != 0);
    check_val("post_rst_zero_vertices", sum, 0);
    check_val("post_rst_last_idx", sidx[nstart-1], E_CLOSED4 - 1);

    repeat (2) step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/poly_line_sequencer.md
# poly_line_sequencer

- Stores up to MAXV vertices and sequences the shared `draw_line` engine through every polygon edge: one start/done handshake per edge, then one completion pulse.
- Sits between the scene/game logic that supplies vertices and the line engine whose pixel outputs drive `vga_adapter`.
- Replaces ad-hoc per-demo edge muxing with one reusable scheduler.

## Interface
Parameters:
- CORDW, 12: signed coordinate width; must match the `draw_line` CORDW.
- MAXV, 8: vertex storage depth; power of two, at least 2.

Ports:
- clk  in  1  system clock (CLOCK_50 at top level)
- rst  in  1  reset; synchronous, active-high
- vtx_we  in  1  write vertex vtx_idx; accepted only in IDLE
- vtx_idx  in  $clog2(MAXV)  vertex slot
- vtx_x, vtx_y  in  CORDW signed  vertex coordinates
- nverts  in  $clog2(MAXV)+1  vertex count; sampled on accepted go; values above MAXV clamp to MAXV
- closed  in  1  draw the closing edge from last vertex to vertex 0; sampled on accepted go
- go  in  1  request a drawing pass; accepted only in IDLE
- busy  out  1  pass in progress
- done  out  1  one-cycle pulse at end of pass
- line_start  out  1  one-cycle start to the line engine
- line_x0, line_y0, line_x1, line_y1  out  CORDW signed  current edge endpoints
- line_idx  out  $clog2(MAXV)  index of the current edge's first vertex
- line_done  in  1  line engine completion pulse

## Operation
- Vertex store: MAXV x (x,y) registers, all cleared to 0 on rst. Written on vtx_we in IDLE only; writes in any other state are dropped.
- Edge count E:
  - Open pass: E = n-1.
  - Closed pass: E = n.
  - Exception: n = 2 with closed set gives E = 1 (no duplicate return edge).
  - n is the clamped nverts.
- Edge i runs from vertex i to vertex i+1. The closing edge runs from vertex n-1 to vertex 0.
- FSM states: IDLE, LOAD, START, WAIT, FIN.
  - IDLE: on go, latch n and closed, clear the edge counter. If E = 0 (n < 2), go to FIN. Otherwise go to LOAD.
  - LOAD: register line_x0/y0/x1/y1 and line_idx for the current edge, then go to START.
  - START: line_start = 1 for exactly this cycle, then go to WAIT.
  - WAIT: hold endpoints. On line_done, go to FIN if this was the last edge; otherwise increment the edge counter and go to LOAD.
  - FIN: done = 1 for one cycle, then go to IDLE.
- line_done is sampled only in WAIT; it is ignored in every other state.
- go while busy is ignored; no queuing.
- rst at any time, including mid-pass: state goes to IDLE, all outputs go to 0, vertex store is cleared. No further line_start is issued.
- Edge counter and index arithmetic is unsigned with width $clog2(MAXV)+1. Coordinates pass through unmodified; no arithmetic is applied to them.

## Timing
- Reset values: busy, done, line_start, line_x0, line_y0, line_x1, line_y1 and line_idx are all 0.
- Pass timing, with go sampled at edge c:
  - LOAD is the state during cycle c+1; busy is high from cycle c+1.
  - Endpoints are valid from cycle c+2. line_start is high in cycle c+2 only.
  - Endpoints stay stable from line_start until the next LOAD.
- Inter-edge latency: line_done in cycle k gives line_start of the next edge in cycle k+2.
- Last edge: line_done in cycle k gives done = 1 and busy = 0 in cycle k+1. IDLE follows in cycle k+2, and go is accepted there.
- Degenerate pass (n < 2): go at c gives done in cycle c+1. No line_start is issued.
- A vtx_we in the same cycle as an accepted go takes effect, because the store is not read until LOAD.

## Configuration
- POLY_LINE_SEQUENCER_CLOSE_EN:
  - Defined: closing-edge logic is compiled in and the closed port is honoured as specified above.
  - Undefined: the closed port is ignored (treated as 0) and every pass is an open polyline with E = n-1; the last-to-first mux path is removed.

## Test plan
- Write (20,20), (100,100), (100,350), (20,430); nverts = 4, closed = 1, go. Engine model returns line_done 5 cycles after each start. Required: 4 starts with endpoints (20,20)->(100,100), (100,100)->(100,350), (100,350)->(20,430), (20,430)->(20,20); line_idx 0..3; a single done pulse 1 cycle after the 4th line_done.
- Same vertices with closed = 0, or with the macro undefined and closed = 1. Required: exactly 3 starts, the last being (100,350)->(20,430).
- nverts = 1, go at cycle c. Required: no line_start, done in cycle c+1. nverts = 2 with closed = 1: exactly 1 edge.
- Mid-pass: go again and vtx_we to slot 0 while in WAIT. Required: no effect on busy or endpoints, and slot 0 unchanged when read on the next pass. Spurious line_done in START: ignored.
- Assert rst during the 2nd edge's WAIT. Required: next cycle busy = 0, all outputs 0, no line_start afterwards; a following pass reads all vertices as (0,0).
